// File: rtl/ttm4_step_sequencer.sv
// ttm4_step_sequencer: instruction phase sequencer for the TTM4 4-bit CPU core.
// Each instruction is walked through FETCH (IMEM handshake), DECODE, EXEC and
// COMMIT, with optional idle WAIT cycles between instructions while running.
//
// Ports:
//   CLK        system clock, rising edge
//   RST        synchronous reset, active-high
//   RUN        level, free-run instructions
//   STEP       1-cycle pulse, execute exactly one instruction
//   DIV        idle cycles inserted after each COMMIT while RUN (0 = none)
//   IMEM_ACK   instruction memory opcode valid this cycle
//   IMEM_REQ   instruction memory request, held until ACK
//   IR_LD      latch instruction register (IMEM_REQ & IMEM_ACK, combinational)
//   DEC_EN     decoder output enable (DECODE, EXEC)
//   ST_EN      register/flag store window (EXEC)
//   PC_STEP    PC increment-or-load strobe (COMMIT)
//   BUSY       sequencer not idle
//   ERR        sticky fetch timeout, cleared only by RST
//   INSTR_CNT  retired instruction count, wrapping
//
// Optional feature macro TTM4_SEQ_BRK_EN adds a PC breakpoint:
//   PC, BRK_ADDR, BRK_VALID inputs and sticky BRK_HIT output.
//   A fetch started under RUN with BRK_VALID and PC == BRK_ADDR is abandoned
//   in its first cycle (no IMEM_REQ) and the sequencer returns to IDLE.

module ttm4_step_sequencer #(
  parameter int unsigned DIV_W  = 4,
  parameter int unsigned CNT_W  = 16,
  parameter int unsigned TO_CYC = 15
`ifdef TTM4_SEQ_BRK_EN
  , parameter int unsigned PC_W = 4
`endif
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic             RUN,
  input  logic             STEP,
  input  logic [DIV_W-1:0] DIV,
  input  logic             IMEM_ACK,
`ifdef TTM4_SEQ_BRK_EN
  input  logic [PC_W-1:0]  PC,
  input  logic [PC_W-1:0]  BRK_ADDR,
  input  logic             BRK_VALID,
  output logic             BRK_HIT,
`endif
  output logic             IMEM_REQ,
  output logic             IR_LD,
  output logic             DEC_EN,
  output logic             ST_EN,
  output logic             PC_STEP,
  output logic             BUSY,
  output logic             ERR,
  output logic [CNT_W-1:0] INSTR_CNT
);

  localparam int unsigned TO_W = 8;

  typedef enum logic [2:0] {
    sIdle   = 3'd0,
    sFetch  = 3'd1,
    sDecode = 3'd2,
    sExec   = 3'd3,
    sCommit = 3'd4,
    sWait   = 3'd5
  } seqState_t;

  seqState_t        state, stateNext;
  logic [DIV_W-1:0] waitCnt, waitCntNext;
  logic [TO_W-1:0]  toCnt, toCntNext;
  logic             errQ, errSet;
  logic             runFetch, stepFetch;
  logic             reqQ, decQ, stQ, pcQ, busyQ;
  logic [CNT_W-1:0] cntQ;

`ifdef TTM4_SEQ_BRK_EN
  logic fetchChk, fetchChkNext;
  logic brkQ;
  logic brkTrip_c;

  // First fetch cycle of a RUN-started instruction sees the final PC value
  assign brkTrip_c = (state == sFetch) && fetchChk && BRK_VALID && (PC == BRK_ADDR);
`endif

  // Next-state logic
  always_comb begin
    stateNext   = state;
    waitCntNext = waitCnt;
    toCntNext   = toCnt;
    errSet      = 1'b0;
    runFetch    = 1'b0;
    stepFetch   = 1'b0;
`ifdef TTM4_SEQ_BRK_EN
    fetchChkNext = 1'b0;
`endif
    case (state)
      sIdle: begin
        if (!errQ) begin
          if (RUN)       runFetch  = 1'b1;
          else if (STEP) stepFetch = 1'b1;
        end
      end
      sFetch: begin
        if (IMEM_ACK) begin
          stateNext = sDecode;
        end else if (toCnt == TO_W'(TO_CYC - 1)) begin
          stateNext = sIdle;
          errSet    = 1'b1;
        end else begin
          toCntNext = toCnt + TO_W'(1);
        end
`ifdef TTM4_SEQ_BRK_EN
        if (brkTrip_c) begin
          stateNext = sIdle;
          errSet    = 1'b0;
        end
`endif
      end
      sDecode: stateNext = sExec;
      sExec:   stateNext = sCommit;
      sCommit: begin
        if (!RUN) begin
          stateNext = sIdle;
        end else if (DIV != '0) begin
          stateNext   = sWait;
          waitCntNext = DIV;
        end else begin
          runFetch = 1'b1;
        end
      end
      sWait: begin
        if (!RUN) begin
          stateNext = sIdle;
        end else if (waitCnt == DIV_W'(1)) begin
          runFetch = 1'b1;
        end else begin
          waitCntNext = waitCnt - DIV_W'(1);
        end
      end
      default: stateNext = sIdle;
    endcase

    // Every fetch starts with a fresh timeout count
    if (runFetch || stepFetch) begin
      stateNext = sFetch;
      toCntNext = '0;
    end
`ifdef TTM4_SEQ_BRK_EN
    fetchChkNext = runFetch;
`endif
  end

  // State, counters and registered strobes (strobes follow the next state)
  always_ff @(posedge CLK) begin
    if (RST) begin
      state   <= sIdle;
      waitCnt <= '0;
      toCnt   <= '0;
      errQ    <= 1'b0;
      cntQ    <= '0;
      reqQ    <= 1'b0;
      decQ    <= 1'b0;
      stQ     <= 1'b0;
      pcQ     <= 1'b0;
      busyQ   <= 1'b0;
`ifdef TTM4_SEQ_BRK_EN
      fetchChk <= 1'b0;
      brkQ     <= 1'b0;
`endif
    end else begin
      state   <= stateNext;
      waitCnt <= waitCntNext;
      toCnt   <= toCntNext;
      if (errSet) errQ <= 1'b1;
      if (state == sCommit) cntQ <= cntQ + CNT_W'(1);
      reqQ  <= (stateNext == sFetch);
      decQ  <= (stateNext == sDecode) || (stateNext == sExec);
      stQ   <= (stateNext == sExec);
      pcQ   <= (stateNext == sCommit);
      busyQ <= (stateNext != sIdle);
`ifdef TTM4_SEQ_BRK_EN
      fetchChk <= fetchChkNext;
      if (brkTrip_c)                                 brkQ <= 1'b1;
      else if (state == sIdle && stateNext == sFetch) brkQ <= 1'b0;
`endif
    end
  end

`ifdef TTM4_SEQ_BRK_EN
  assign IMEM_REQ = reqQ & ~brkTrip_c;
  assign BRK_HIT  = brkQ;
`else
  assign IMEM_REQ = reqQ;
`endif
  assign IR_LD     = IMEM_REQ & IMEM_ACK;
  assign DEC_EN    = decQ;
  assign ST_EN     = stQ;
  assign PC_STEP   = pcQ;
  assign BUSY      = busyQ;
  assign ERR       = errQ;
  assign INSTR_CNT = cntQ;

endmodule

// File: tb/tb_ttm4_step_sequencer.sv
// tb_ttm4_step_sequencer: self-checking bench for ttm4_step_sequencer.
// Expected strobe traces are built per instruction from phase lengths
// (fetch = ack delay + 1, decode 1, exec 1, commit 1, wait = DIV at commit).

module tb_ttm4_step_sequencer;

  localparam int unsigned DIV_W  = 4;
  localparam int unsigned CNT_W  = 16;
  localparam int unsigned TO_CYC = 15;
  localparam int unsigned PC_W   = 4;
  localparam int          MAXC   = 512;

  logic             tb_CLK = 1'b0;
  logic             rst, run, step, imemAck;
  logic [DIV_W-1:0] div;
  logic             imemReq, irLd, decEn, stEn, pcStep, busy, err;
  logic [CNT_W-1:0] instrCnt;
`ifdef TTM4_SEQ_BRK_EN
  logic [PC_W-1:0]  pcReg, brkAddr;
  logic             brkValid, brkHit;
`endif

  int checks = 0;
  int errors = 0;
  int expCnt = 0;

  // Expected per-cycle trace, index 0 = first cycle after the start edge
  bit               sReq [MAXC];
  bit               sDec [MAXC];
  bit               sSt  [MAXC];
  bit               sPc  [MAXC];
  bit               sAck [MAXC];
  bit               sRun [MAXC];
  logic [DIV_W-1:0] sDiv [MAXC];
  int               sLen;
  int               sCommits;

  always #5 tb_CLK = ~tb_CLK;

  ttm4_step_sequencer #(
    .DIV_W (DIV_W),
    .CNT_W (CNT_W),
    .TO_CYC(TO_CYC)
  ) dut (
    .CLK      (tb_CLK),
    .RST      (rst),
    .RUN      (run),
    .STEP     (step),
    .DIV      (div),
    .IMEM_ACK (imemAck),
`ifdef TTM4_SEQ_BRK_EN
    .PC       (pcReg),
    .BRK_ADDR (brkAddr),
    .BRK_VALID(brkValid),
    .BRK_HIT  (brkHit),
`endif
    .IMEM_REQ (imemReq),
    .IR_LD    (irLd),
    .DEC_EN   (decEn),
    .ST_EN    (stEn),
    .PC_STEP  (pcStep),
    .BUSY     (busy),
    .ERR      (err),
    .INSTR_CNT(instrCnt)
  );

`ifdef TTM4_SEQ_BRK_EN
  // Simple program counter: advances on every PC_STEP
  always @(posedge tb_CLK) begin
    if (rst)         pcReg <= '0;
    else if (pcStep) pcReg <= pcReg + PC_W'(1);
  end
`endif

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic tick();
    @(posedge tb_CLK);
    #1;
  endtask

  // Build the expected trace of a RUN session. RUN is held until cycle dropC
  // (or forced low at the last instruction's commit).
  function automatic void buildSchedule(input int nInstr, input int dropC,
                                        input int delays[$], input int divs[$]);
    int c = 0;
    int stopC = dropC;
    bit done = 1'b0;
    for (int i = 0; i < MAXC; i++) begin
      sReq[i] = 1'b0; sDec[i] = 1'b0; sSt[i] = 1'b0; sPc[i] = 1'b0;
      sAck[i] = 1'($urandom_range(0, 1));
      sDiv[i] = DIV_W'($urandom);
    end
    sCommits = 0;
    for (int i = 0; i < nInstr && !done; i++) begin
      for (int k = 0; k <= delays[i]; k++) begin
        sReq[c] = 1'b1;
        sAck[c] = (k == delays[i]);
        c++;
      end
      sDec[c] = 1'b1; c++;
      sDec[c] = 1'b1; sSt[c] = 1'b1; c++;
      sPc[c] = 1'b1;
      sDiv[c] = DIV_W'(divs[i]);
      sCommits++;
      if (i == nInstr - 1 && stopC > c) stopC = c;
      if (c >= stopC) begin
        done = 1'b1;
        c++;
      end else begin
        c++;
        for (int w = 0; w < divs[i] && !done; w++) begin
          if (c >= stopC) done = 1'b1;
          c++;
        end
      end
    end
    sLen = c;
    for (int i = 0; i < MAXC; i++) sRun[i] = (i < stopC);
  endfunction

  // Drive a built schedule and compare every cycle
  task automatic runSchedule(input string name);
    step = 1'b0;
    run  = 1'b1;
    tick();
    for (int c = 0; c < sLen; c++) begin
      imemAck = sAck[c];
      div     = sDiv[c];
      run     = sRun[c];
      #1;
      checks++;
      if (imemReq !== sReq[c]) begin
        errors++;
        $display("FAIL %s imem_req c=%0d got=%b exp=%b", name, c, imemReq, sReq[c]);
      end
      checks++;
      if (irLd !== (sReq[c] & sAck[c])) begin
        errors++;
        $display("FAIL %s ir_ld c=%0d got=%b exp=%b", name, c, irLd, sReq[c] & sAck[c]);
      end
      checks++;
      if (decEn !== sDec[c] || stEn !== sSt[c]) begin
        errors++;
        $display("FAIL %s dec_st c=%0d got=%b%b exp=%b%b", name, c, decEn, stEn, sDec[c], sSt[c]);
      end
      checks++;
      if (pcStep !== sPc[c] || busy !== 1'b1) begin
        errors++;
        $display("FAIL %s pc_busy c=%0d got=%b%b exp=%b1", name, c, pcStep, busy, sPc[c]);
      end
      tick();
    end
    run = 1'b0;
    imemAck = 1'b0;
    #1;
    expCnt += sCommits;
    checks++;
    if (busy !== 1'b0 || err !== 1'b0) begin
      errors++;
      $display("FAIL %s end_idle got busy=%b err=%b exp busy=0 err=0", name, busy, err);
    end
    checks++;
    if (instrCnt !== CNT_W'(expCnt)) begin
      errors++;
      $display("FAIL %s instr_cnt got=%0d exp=%0d", name, instrCnt, CNT_W'(expCnt));
    end
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    rst = 1'b0;
    #1;
    expCnt = 0;
    checks++;
    if ({imemReq, irLd, decEn, stEn, pcStep, busy, err} !== 7'b0) begin
      errors++;
      $display("FAIL reset strobes got=%b exp=0000000", {imemReq, irLd, decEn, stEn, pcStep, busy, err});
    end
    checks++;
    if (instrCnt !== '0) begin
      errors++;
      $display("FAIL reset instr_cnt got=%0d exp=0", instrCnt);
    end
  endtask

  task automatic test_single_step();
    bit eReq, eDec, eSt, ePc, eBusy;
    imemAck = 1'b1;
    run  = 1'b0;
    step = 1'b1;
    tick();
    for (int off = 1; off <= 6; off++) begin
      step = (off == 4);
      #1;
      eReq  = (off == 1);
      eDec  = (off == 2 || off == 3);
      eSt   = (off == 3);
      ePc   = (off == 4);
      eBusy = (off <= 4);
      checks++;
      if ({imemReq, irLd, decEn, stEn, pcStep, busy} !== {eReq, eReq, eDec, eSt, ePc, eBusy}) begin
        errors++;
        $display("FAIL single_step off=%0d got=%b exp=%b", off,
                 {imemReq, irLd, decEn, stEn, pcStep, busy}, {eReq, eReq, eDec, eSt, ePc, eBusy});
      end
      tick();
    end
    step = 1'b0;
    expCnt += 1;
    checks++;
    if (instrCnt !== CNT_W'(expCnt)) begin
      errors++;
      $display("FAIL single_step instr_cnt got=%0d exp=%0d", instrCnt, expCnt);
    end
  endtask

  task automatic test_reset_mid_exec();
    imemAck = 1'b1;
    step = 1'b1;
    tick();
    step = 1'b0;
    tick();
    tick();
    checks++;
    if (stEn !== 1'b1) begin
      errors++;
      $display("FAIL rst_mid_exec in_exec st_en got=%b exp=1", stEn);
    end
    rst = 1'b1;
    for (int k = 0; k < 2; k++) begin
      tick();
      checks++;
      if ({busy, stEn, pcStep, decEn, imemReq} !== 5'b0 || instrCnt !== '0) begin
        errors++;
        $display("FAIL rst_mid_exec k=%0d got=%b cnt=%0d exp=00000 cnt=0", k,
                 {busy, stEn, pcStep, decEn, imemReq}, instrCnt);
      end
    end
    rst = 1'b0;
    expCnt = 0;
    tick();
    checks++;
    if (busy !== 1'b0 || pcStep !== 1'b0 || instrCnt !== '0) begin
      errors++;
      $display("FAIL rst_mid_exec after got busy=%b pc=%b cnt=%0d exp 0 0 0", busy, pcStep, instrCnt);
    end
  endtask

  task automatic test_free_run();
    imemAck = 1'b1;
    div = '0;
    run = 1'b1;
    tick();
    for (int c = 1; c <= 45; c++) begin
      run = (c <= 39);
      #1;
      checks++;
      if (pcStep !== ((c % 4 == 0) && c <= 40) || busy !== (c <= 40)) begin
        errors++;
        $display("FAIL free_run c=%0d got pc=%b busy=%b exp pc=%b busy=%b", c, pcStep, busy,
                 (c % 4 == 0) && c <= 40, c <= 40);
      end
      tick();
    end
    expCnt += 10;
    checks++;
    if (instrCnt !== CNT_W'(expCnt)) begin
      errors++;
      $display("FAIL free_run instr_cnt got=%0d exp=%0d", instrCnt, expCnt);
    end
  endtask

  task automatic test_div_run();
    int dl[$];
    int dv[$];
    for (int i = 0; i < 10; i++) begin
      dl.push_back(0);
      dv.push_back(3);
    end
    // Fourth instruction starts fetch at cycle 21; RUN drops in its DECODE
    buildSchedule(10, 22, dl, dv);
    runSchedule("div_run");
  endtask

  task automatic test_ack_delay();
    int dl[$];
    int dv[$];
    dl.push_back(5);
    dv.push_back(0);
    buildSchedule(1, MAXC, dl, dv);
    runSchedule("ack_delay");
  endtask

  task automatic test_random();
    int dl[$];
    int dv[$];
    int n;
    for (int r = 0; r < 8; r++) begin
      dl.delete();
      dv.delete();
      n = $urandom_range(1, 6);
      for (int i = 0; i < n; i++) begin
        dl.push_back($urandom_range(0, 6));
        dv.push_back($urandom_range(0, 4));
      end
      buildSchedule(n, $urandom_range(0, 60), dl, dv);
      runSchedule("random");
    end
  endtask

  task automatic test_timeout();
    imemAck = 1'b0;
    step = 1'b1;
    tick();
    step = 1'b0;
    for (int c = 0; c < int'(TO_CYC); c++) begin
      #1;
      checks++;
      if (imemReq !== 1'b1 || busy !== 1'b1 || err !== 1'b0) begin
        errors++;
        $display("FAIL timeout fetch c=%0d got req=%b busy=%b err=%b exp 1 1 0", c, imemReq, busy, err);
      end
      tick();
    end
    checks++;
    if (imemReq !== 1'b0 || busy !== 1'b0 || err !== 1'b1) begin
      errors++;
      $display("FAIL timeout expire got req=%b busy=%b err=%b exp 0 0 1", imemReq, busy, err);
    end
    imemAck = 1'b1;
    for (int c = 0; c < 6; c++) begin
      run  = (c < 3);
      step = (c >= 3);
      tick();
      checks++;
      if (busy !== 1'b0 || imemReq !== 1'b0 || err !== 1'b1) begin
        errors++;
        $display("FAIL timeout locked c=%0d got busy=%b req=%b err=%b exp 0 0 1", c, busy, imemReq, err);
      end
    end
    run  = 1'b0;
    step = 1'b0;
    rst  = 1'b1;
    tick();
    rst = 1'b0;
    expCnt = 0;
    tick();
    checks++;
    if (err !== 1'b0 || instrCnt !== '0) begin
      errors++;
      $display("FAIL timeout rst_clear got err=%b cnt=%0d exp 0 0", err, instrCnt);
    end
  endtask

`ifdef TTM4_SEQ_BRK_EN
  task automatic test_breakpoint();
    int c;
    bit sawReq3;
    bit stepped;
    rst = 1'b1;
    tick();
    rst = 1'b0;
    expCnt   = 0;
    brkAddr  = PC_W'(3);
    brkValid = 1'b1;
    imemAck  = 1'b1;
    div      = '0;
    run      = 1'b1;
    sawReq3  = 1'b0;
    tick();
    for (c = 1; c < 60; c++) begin
      if (imemReq && pcReg == PC_W'(3)) sawReq3 = 1'b1;
      if (!busy) break;
      tick();
    end
    run = 1'b0;
    checks++;
    if (c >= 60) begin
      errors++;
      $display("FAIL brk halt got busy after %0d cycles exp halt", c);
    end
    checks++;
    if (sawReq3 || pcReg !== PC_W'(3) || brkHit !== 1'b1 || instrCnt !== CNT_W'(3)) begin
      errors++;
      $display("FAIL brk state got req3=%b pc=%0d hit=%b cnt=%0d exp 0 3 1 3", sawReq3, pcReg, brkHit, instrCnt);
    end
    step = 1'b1;
    tick();
    step = 1'b0;
    checks++;
    if (brkHit !== 1'b0 || imemReq !== 1'b1) begin
      errors++;
      $display("FAIL brk step_start got hit=%b req=%b exp 0 1", brkHit, imemReq);
    end
    stepped = 1'b0;
    for (int k = 0; k < 10; k++) begin
      if (pcStep && pcReg == PC_W'(3)) stepped = 1'b1;
      if (!busy) break;
      tick();
    end
    checks++;
    if (!stepped || pcReg !== PC_W'(4) || brkHit !== 1'b0 || instrCnt !== CNT_W'(4)) begin
      errors++;
      $display("FAIL brk step_past got stepped=%b pc=%0d hit=%b cnt=%0d exp 1 4 0 4", stepped, pcReg, brkHit, instrCnt);
    end
    brkValid = 1'b0;
  endtask
`endif

  initial begin
    rst     = 1'b1;
    run     = 1'b0;
    step    = 1'b0;
    div     = '0;
    imemAck = 1'b0;
`ifdef TTM4_SEQ_BRK_EN
    brkAddr  = '0;
    brkValid = 1'b0;
`endif
    test_reset();
    test_single_step();
    test_reset_mid_exec();
    test_free_run();
    test_div_run();
    test_ack_delay();
    test_random();
    test_timeout();
`ifdef TTM4_SEQ_BRK_EN
    test_breakpoint();
`endif
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
